// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants and types for the wishbone request master
package wb_pkg;

  localparam int WB_DW = 32;
  localparam int WB_AW = 26;
  localparam int WB_SW = WB_DW / 8;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    BUS  = 2'd2,
    RSP  = 2'd3
  } wbm_state_t;

  typedef struct packed {
    logic             we;
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
    logic [WB_SW-1:0] sel;
  } wb_req_t;

endpackage

// File: rtl/wb_req_fifo.sv
// rtl/wb_req_fifo.sv - synchronous request FIFO with registered-pointer full/empty flags
module wb_req_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output wb_req_t pop_data,
  output logic    full,
  output logic    empty
);

  localparam int PW = $clog2(DEPTH);

  // Extra MSB on each pointer distinguishes full from empty when the indices match
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  wb_req_t       mem [DEPTH];

  // Pointer advance; flags come from these registers so a same-cycle pop never unblocks a push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Entry storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[PW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[PW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/wb_req_master.sv
// rtl/wb_req_master.sv - wishbone classic master driving one bus cycle per queued request
module wb_req_master
  import wb_pkg::*;
#(
  parameter int DW         = WB_DW,
  parameter int AW         = WB_AW,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic            sys_clk,
  input  logic            RESETN,
  input  logic            sdr_init_done,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_data,
  input  logic [DW/8-1:0] req_sel,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_we,
  output logic [DW-1:0]   rsp_data,
  output logic            rsp_err,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_addr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [2:0]      wb_cti_o,
  input  logic            wb_ack_i,
  input  logic [DW-1:0]   wb_dat_i,
  output logic [15:0]     txn_cnt,
  output logic [7:0]      err_cnt
);

  localparam int TW = $clog2(TIMEOUT);

  localparam logic [1:0] ST_INIT = INIT;
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUS  = BUS;
  localparam logic [1:0] ST_RSP  = RSP;

  logic [1:0]    state;
  logic [TW-1:0] tmo_cnt;
  logic          wb_stb;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  wb_req_t       push_req;
  wb_req_t       head_req;
  logic          bus_ack;
  logic          bus_tmo;
  logic          rsp_take;

  assign req_ready = !fifo_full && (state != ST_INIT);
  assign fifo_push = req_valid && req_ready;
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;

  assign bus_ack   = (state == ST_BUS) && wb_ack_i;
  assign bus_tmo   = (state == ST_BUS) && !wb_ack_i && (tmo_cnt == TW'(TIMEOUT - 1));
  assign rsp_take  = (state == ST_RSP) && rsp_ready;

  assign wb_cyc_o  = wb_stb;
  assign wb_stb_o  = wb_stb;
  assign wb_cti_o  = CTI_CLASSIC;

  // Reads are normalised on entry: no write data, all byte lanes enabled
  always_comb begin
    push_req      = '0;
    push_req.we   = req_we;
    push_req.addr = req_addr;
    push_req.data = req_we ? req_data : '0;
    push_req.sel  = req_we ? req_sel : '1;
  end

  wb_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (sys_clk),
    .rst_n     (RESETN),
    .push      (fifo_push),
    .push_data (push_req),
    .pop       (fifo_pop),
    .pop_data  (head_req),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Bus/response sequencer; bus fields return to zero whenever the strobe drops
  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      state     <= ST_INIT;
      tmo_cnt   <= '0;
      wb_stb    <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_addr_o <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (sdr_init_done) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (!fifo_empty) begin
            wb_stb    <= 1'b1;
            wb_we_o   <= head_req.we;
            wb_addr_o <= head_req.addr;
            wb_dat_o  <= head_req.data;
            wb_sel_o  <= head_req.sel;
            tmo_cnt   <= '0;
            state     <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (bus_ack || bus_tmo) begin
            wb_stb    <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_addr_o <= '0;
            wb_dat_o  <= '0;
            wb_sel_o  <= '0;
            rsp_valid <= 1'b1;
            rsp_we    <= wb_we_o;
            rsp_err   <= bus_tmo;
            rsp_data  <= (bus_ack && !wb_we_o) ? wb_dat_i : '0;
            state     <= ST_RSP;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Completed-transaction count wraps; timeout count saturates
  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      txn_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (rsp_take) txn_cnt <= txn_cnt + 16'd1;
      if (bus_tmo && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_wb_req_master.sv
// tb/tb_wb_req_master.sv - self-checking bench for wb_req_master
module tb_wb_req_master;

  logic        sys_clk = 1'b0;
  logic        RESETN;
  logic        sdr_init_done;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [25:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_sel;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_we;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [25:0] wb_addr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic        wb_ack_i = 1'b0;
  logic [31:0] wb_dat_i = 32'h0;
  logic [15:0] txn_cnt;
  logic [7:0]  err_cnt;

  wb_req_master #(.DW(32), .AW(26), .FIFO_DEPTH(4), .TIMEOUT(16)) dut (
    .sys_clk(sys_clk), .RESETN(RESETN), .sdr_init_done(sdr_init_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i),
    .txn_cnt(txn_cnt), .err_cnt(err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct { logic we; logic [25:0] addr; logic [31:0] data; logic [3:0] sel; } bus_t;
  typedef struct { logic we; logic [31:0] data; logic err; } rsp_t;

  int total = 0;
  int bad   = 0;
  bus_t exp_bus[$];
  rsp_t exp_rsp[$];
  logic [31:0] shadow [int];
  logic [31:0] smem [int];
  int  model_txn = 0;
  int  model_err = 0;
  bit  slave_en = 1, slave_rand = 0, spurious = 0, rsp_hold = 0, rsp_rand = 0;
  int  gap_viol = 0, idle_viol = 0, lat_viol = 0;
  int  stb_run = 0, last_stb_len = 0;
  logic [31:0] last_rd = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [25:0] a);
    return 32'hC0DE0000 ^ {6'b0, a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Reference model: expected bus cycle and response, memory updated in request order
  task automatic model_add(input logic we, input logic [25:0] addr, input logic [31:0] data,
                           input logic [3:0] sel, input bit dead);
    bus_t b;
    rsp_t r;
    logic [31:0] cur;
    b.we = we; b.addr = addr; b.data = we ? data : 32'h0; b.sel = we ? sel : 4'hF;
    exp_bus.push_back(b);
    cur = shadow.exists(int'(addr)) ? shadow[int'(addr)] : dflt(addr);
    r.we = we; r.err = dead; r.data = 32'h0;
    if (dead) model_err++;
    else if (we) shadow[int'(addr)] = merge(cur, data, sel);
    else r.data = cur;
    exp_rsp.push_back(r);
  endtask

  task automatic push_req(input logic we, input logic [25:0] addr, input logic [31:0] data,
                          input logic [3:0] sel, input bit dead);
    int n;
    n = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_data = data; req_sel = sel;
    @(negedge sys_clk);
    while (!req_ready && n < 200) begin n++; @(negedge sys_clk); end
    if (!req_ready) chk("push_ready", req_ready, 1'b1);
    else model_add(we, addr, data, sel, dead);
    @(posedge sys_clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_rsp.size() != 0 || rsp_valid || wb_stb_o) && n < 600) begin
      n++; @(negedge sys_clk);
    end
    if (n >= 600) chk({tag, "_drain"}, exp_rsp.size(), 0);
    repeat (2) @(negedge sys_clk);
  endtask

  // Slave model: memory with one-cycle (or random) ack latency, optional stray acks
  int wait_n = 0;
  always @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      wb_ack_i <= 1'b0;
      wait_n = 0;
    end else begin
      wb_ack_i <= 1'b0;
      if (spurious) begin
        wb_ack_i <= 1'b1;
        wb_dat_i <= $urandom;
      end else if (wb_stb_o && !wb_ack_i && slave_en &&
                   (!slave_rand || wait_n >= 3 || $urandom_range(0, 1) == 1)) begin
        if (wb_we_o)
          smem[int'(wb_addr_o)] = merge(smem.exists(int'(wb_addr_o)) ? smem[int'(wb_addr_o)]
                                        : dflt(wb_addr_o), wb_dat_o, wb_sel_o);
        else
          wb_dat_i <= smem.exists(int'(wb_addr_o)) ? smem[int'(wb_addr_o)] : dflt(wb_addr_o);
        wb_ack_i <= 1'b1;
        wait_n = 0;
      end else begin
        wait_n = wb_stb_o ? wait_n + 1 : 0;
      end
    end
  end

  // Response consumer: drives rsp_ready and checks responses in order against the model
  always @(posedge sys_clk) begin
    #1;
    rsp_ready = rsp_hold ? 1'b0 : (rsp_rand ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  always @(negedge sys_clk) begin
    rsp_t r;
    if (RESETN && rsp_valid && rsp_ready) begin
      if (exp_rsp.size() == 0) chk("rsp_extra", exp_rsp.size(), 1);
      else begin
        r = exp_rsp.pop_front();
        chk("rsp_we", rsp_we, r.we);
        chk("rsp_data", rsp_data, r.data);
        chk("rsp_err", rsp_err, r.err);
        model_txn++;
        if (!r.we && !r.err) last_rd = rsp_data;
      end
    end
  end

  // Bus monitor: cycle contents/order, idle-bus values, gap after ack, ack-to-response latency
  logic prev_stb = 1'b0;
  logic ack_taken = 1'b0;
  always @(negedge sys_clk) begin
    bus_t b;
    if (wb_cyc_o !== wb_stb_o || wb_cti_o !== 3'b000) idle_viol++;
    if (!wb_stb_o && (wb_we_o !== 1'b0 || wb_addr_o !== 26'h0 || wb_dat_o !== 32'h0 || wb_sel_o !== 4'h0))
      idle_viol++;
    if (ack_taken && wb_stb_o) gap_viol++;
    if (ack_taken && !rsp_valid) lat_viol++;
    ack_taken = wb_stb_o && wb_ack_i;
    if (wb_stb_o && !prev_stb) begin
      if (exp_bus.size() == 0) chk("bus_unexpected", exp_bus.size(), 1);
      else begin
        b = exp_bus.pop_front();
        chk("bus_we", wb_we_o, b.we);
        chk("bus_addr", wb_addr_o, b.addr);
        chk("bus_dat", wb_dat_o, b.data);
        chk("bus_sel", wb_sel_o, b.sel);
      end
    end
    if (wb_stb_o) stb_run++;
    else if (prev_stb) begin last_stb_len = stb_run; stb_run = 0; end
    prev_stb = wb_stb_o;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESETN = 1'b1; sdr_init_done = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_data = '0; req_sel = '0;
    #1 RESETN = 1'b0;
    @(negedge sys_clk);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_stb", wb_stb_o, 1'b0);
    chk("rst_cyc", wb_cyc_o, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_txn", txn_cnt, 16'h0);
    chk("rst_err", err_cnt, 8'h0);
    @(posedge sys_clk); #1 RESETN = 1'b1;

    // 1: request offered before init completes is held off
    req_valid = 1'b1; req_we = 1'b1; req_addr = 26'h3; req_data = 32'h11223344; req_sel = 4'hF;
    repeat (5) @(negedge sys_clk);
    chk("t1_no_stb_pre_init", wb_stb_o, 1'b0);
    chk("t1_not_ready_pre_init", req_ready, 1'b0);
    @(posedge sys_clk); #1 sdr_init_done = 1'b1;
    @(negedge sys_clk);
    chk("t1_ready_still_init", req_ready, 1'b0);
    @(negedge sys_clk);
    chk("t1_ready_after_init", req_ready, 1'b1);
    model_add(1'b1, 26'h3, 32'h11223344, 4'hF, 1'b0);
    @(posedge sys_clk); #1 req_valid = 1'b0;
    @(negedge sys_clk);
    chk("t1_stb_lat1", wb_stb_o, 1'b0);
    @(negedge sys_clk);
    chk("t1_stb_lat2", wb_stb_o, 1'b1);
    drain("t1");

    // 2: write then read back the same word
    @(posedge sys_clk); #1;
    push_req(1'b1, 26'h0A5, 32'hDEADBEEF, 4'hF, 1'b0);
    push_req(1'b0, 26'h0A5, 32'h0, 4'h0, 1'b0);
    drain("t2");
    chk("t2_read_data", last_rd, 32'hDEADBEEF);
    chk("t2_txn", txn_cnt, 32'(model_txn));
    chk("t2_err", err_cnt, 8'h0);

    // 3: five back-to-back requests with the slave stalled
    @(posedge sys_clk); #2 slave_en = 1'b0;
    @(posedge sys_clk); #1;
    for (int i = 0; i < 5; i++)
      push_req(1'($urandom_range(0, 1)), 26'($urandom_range(0, 15)), $urandom, 4'($urandom), 1'b0);
    @(negedge sys_clk);
    chk("t3_full", req_ready, 1'b0);
    repeat (3) @(negedge sys_clk);
    chk("t3_still_full", req_ready, 1'b0);
    @(posedge sys_clk); #2 slave_en = 1'b1;
    drain("t3");
    chk("t3_txn", txn_cnt, 32'(model_txn));

    // 4: timeouts on a read and a write; the aborted write must not land
    @(posedge sys_clk); #2 slave_en = 1'b0;
    @(posedge sys_clk); #1;
    push_req(1'b0, 26'h20, 32'h0, 4'h0, 1'b1);
    drain("t4a");
    chk("t4_stb_len", last_stb_len, 16);
    chk("t4_err_cnt1", err_cnt, 8'd1);
    @(posedge sys_clk); #1;
    push_req(1'b1, 26'h21, 32'hA5A5A5A5, 4'hF, 1'b1);
    drain("t4b");
    @(posedge sys_clk); #2 slave_en = 1'b1;
    @(posedge sys_clk); #1;
    push_req(1'b0, 26'h21, 32'h0, 4'h0, 1'b0);
    drain("t4c");
    chk("t4_err_cnt2", err_cnt, 32'(model_err));
    chk("t4_txn", txn_cnt, 32'(model_txn));

    // 5: response held off; it stays stable and no new cycle starts
    @(posedge sys_clk); #2 rsp_hold = 1'b1;
    @(posedge sys_clk); #1;
    push_req(1'b1, 26'($urandom_range(0, 15)), $urandom, 4'($urandom), 1'b0);
    push_req(1'b0, 26'($urandom_range(0, 15)), 32'h0, 4'h0, 1'b0);
    for (int n = 0; n < 50 && !rsp_valid; n++) @(negedge sys_clk);
    for (int i = 0; i < 10; i++) begin
      chk("t5_rsp_valid", rsp_valid, 1'b1);
      chk("t5_no_stb", wb_stb_o, 1'b0);
      chk("t5_rsp_data", rsp_data, exp_rsp[0].data);
      chk("t5_rsp_err", rsp_err, exp_rsp[0].err);
      @(negedge sys_clk);
    end
    @(posedge sys_clk); #2 rsp_hold = 1'b0;
    drain("t5");

    // 6: reset in the middle of a bus cycle
    @(posedge sys_clk); #2 slave_en = 1'b0;
    @(posedge sys_clk); #1;
    push_req(1'b0, 26'h5, 32'h0, 4'h0, 1'b0);
    push_req(1'b1, 26'h6, 32'h12345678, 4'hF, 1'b0);
    for (int n = 0; n < 20 && !wb_stb_o; n++) @(negedge sys_clk);
    chk("t6_stb_before_rst", wb_stb_o, 1'b1);
    @(posedge sys_clk); #2 RESETN = 1'b0;
    #1;
    chk("t6_stb", wb_stb_o, 1'b0);
    chk("t6_cyc", wb_cyc_o, 1'b0);
    chk("t6_rsp_valid", rsp_valid, 1'b0);
    chk("t6_req_ready", req_ready, 1'b0);
    chk("t6_txn", txn_cnt, 16'h0);
    exp_bus.delete(); exp_rsp.delete();
    model_txn = 0; model_err = 0;
    slave_en = 1'b1;
    @(posedge sys_clk); #2 RESETN = 1'b1;
    @(negedge sys_clk);
    chk("t6_init_after_rst", req_ready, 1'b0);
    @(negedge sys_clk);
    chk("t6_ready", req_ready, 1'b1);
    repeat (3) @(negedge sys_clk);
    chk("t6_fifo_flushed", wb_stb_o, 1'b0);

    // 7: stray acks while idle are ignored
    @(posedge sys_clk); #2 spurious = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("t7_stray_rsp", rsp_valid, 1'b0);
    chk("t7_stray_stb", wb_stb_o, 1'b0);
    @(posedge sys_clk); #2 spurious = 1'b0;

    // 8: random traffic, random back-pressure and slave latency, init dropped (ignored)
    @(posedge sys_clk); #2 sdr_init_done = 1'b0; rsp_rand = 1'b1; slave_rand = 1'b1;
    @(posedge sys_clk); #1;
    for (int i = 0; i < 40; i++)
      push_req(1'($urandom_range(0, 1)), 26'($urandom_range(0, 7)), $urandom, 4'($urandom), 1'b0);
    drain("t8");
    chk("t8_txn", txn_cnt, 32'(model_txn));
    chk("t8_err", err_cnt, 32'(model_err));

    chk("gap_violations", gap_viol, 0);
    chk("idle_bus_violations", idle_viol, 0);
    chk("ack_rsp_latency_violations", lat_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
